// File: rtl/mole_pkg.sv
// Shared types and constants for the mole scheduler: slot state encoding,
// LFSR feedback taps, counter widths and a constant-foldable ceil(log2).
package mole_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_UP   = 1'b1
  } slot_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          TICK_W    = 16;
  localparam int          LIFE_W    = 16;

  // Never returns less than 1 so that derived vector widths stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole slot: waits out its spawn gap, holds a mole on a granted hole and
// retires it on a switch edge (hit) or when its lifetime runs out (miss).
module mole_slot
  import mole_pkg::*;
#(
  parameter int N_HOLES   = 18,
  parameter int IDX_W     = 5,
  parameter int SPAWN_GAP = 250,
  parameter int SLOT_ID   = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               start_i,
  input  logic               tick_i,
  input  logic               grant_i,
  input  logic [IDX_W-1:0]   cand_i,
  input  logic [LIFE_W-1:0]  life_ticks_i,
  input  logic [N_HOLES-1:0] edge_i,
  output slot_state_t        state_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               eligible_o,
  output logic               hit_o,
  output logic               miss_o
);

  slot_state_t       state_q;
  logic [TICK_W-1:0] gap_q;
  logic [LIFE_W-1:0] life_q;
  logic [IDX_W-1:0]  idx_q;
  logic              edge_at_idx;

  always_comb begin
    edge_at_idx = 1'b0;
    for (int h = 0; h < N_HOLES; h++) begin
      if (idx_q == IDX_W'(h) && edge_i[h]) edge_at_idx = 1'b1;
    end
  end

  // A hit on the expiry tick wins, so the miss flag is masked by the hit.
  assign hit_o      = (state_q == S_UP) && enable_i && !start_i && edge_at_idx;
  assign miss_o     = (state_q == S_UP) && tick_i && !start_i && !hit_o &&
                      (life_q == LIFE_W'(1));
  assign eligible_o = (state_q == S_IDLE) && (gap_q == '0);
  assign state_o    = state_q;
  assign idx_o      = idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      life_q  <= '0;
      idx_q   <= '0;
    end else if (start_i) begin
      state_q <= S_IDLE;
      gap_q   <= TICK_W'(SLOT_ID);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_i) begin
            state_q <= S_UP;
            idx_q   <= cand_i;
            life_q  <= (life_ticks_i == '0) ? LIFE_W'(1) : life_ticks_i;
          end else if (tick_i && gap_q != '0) begin
            gap_q <= gap_q - TICK_W'(1);
          end
        end
        S_UP: begin
          if (hit_o || miss_o) begin
            state_q <= S_IDLE;
            gap_q   <= TICK_W'(SPAWN_GAP);
          end else if (tick_i) begin
            life_q <= life_q - LIFE_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: tick divider, LFSR hole picker, lowest-slot-first spawn
// grant, switch edge detection and per-cycle hit/miss/wrong reporting.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          N_HOLES   = 18,
  parameter int          N_MOLES   = 3,
  parameter int          TICK_DIV  = 50000,
  parameter int          SPAWN_GAP = 250,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDX_W     = clog2(N_HOLES),
  localparam int         CNT_W     = clog2(N_MOLES + 1)
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     start,
  input  logic [15:0]              life_ticks,
  input  logic [N_HOLES-1:0]       sw,
  output logic [N_HOLES-1:0]       mole_positions,
  output logic [N_MOLES*IDX_W-1:0] mole_idx,
  output logic [N_MOLES-1:0]       mole_valid,
  output logic [CNT_W-1:0]         hit_count,
  output logic [CNT_W-1:0]         miss_count,
  output logic                     wrong
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [TICK_W-1:0]  tick_cnt_q;
  logic               tick;
  logic [15:0]        lfsr_q;
  logic [N_HOLES-1:0] sw_q;
  logic [N_HOLES-1:0] edges;
  logic [IDX_W-1:0]   cand;
  logic               cand_ok;
  logic               found;
  slot_state_t        slot_state [N_MOLES];
  logic [IDX_W-1:0]   slot_idx   [N_MOLES];
  logic [N_MOLES-1:0] eligible, grant, hit_flag, miss_flag;
  logic [CNT_W-1:0]   hit_sum, miss_sum;
  logic [CNT_W-1:0]   hit_count_q, miss_count_q;
  logic               wrong_q;

  assign tick  = enable && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign edges = enable ? (sw & ~sw_q) : '0;
  assign cand  = lfsr_q[IDX_W-1:0];

  // Candidate is checked against registered occupancy, so a freed hole is
  // only reusable from the following cycle.
  always_comb begin
    cand_ok = 1'b0;
    for (int h = 0; h < N_HOLES; h++) begin
      if (cand == IDX_W'(h) && !mole_positions[h]) cand_ok = 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int s = 0; s < N_MOLES; s++) begin
      if (!found && eligible[s]) begin
        grant[s] = enable && !start && cand_ok;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    mole_positions = '0;
    hit_sum        = '0;
    miss_sum       = '0;
    for (int s = 0; s < N_MOLES; s++) begin
      for (int h = 0; h < N_HOLES; h++) begin
        if (slot_state[s] == S_UP && slot_idx[s] == IDX_W'(h)) mole_positions[h] = 1'b1;
      end
      hit_sum  = hit_sum + CNT_W'(hit_flag[s]);
      miss_sum = miss_sum + CNT_W'(miss_flag[s]);
    end
  end

  for (genvar g = 0; g < N_MOLES; g++) begin : g_slot
    mole_slot #(
      .N_HOLES  (N_HOLES),
      .IDX_W    (IDX_W),
      .SPAWN_GAP(SPAWN_GAP),
      .SLOT_ID  (g)
    ) u_slot (
      .clk_i       (CLOCK_50),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .start_i     (start),
      .tick_i      (tick),
      .grant_i     (grant[g]),
      .cand_i      (cand),
      .life_ticks_i(life_ticks),
      .edge_i      (edges),
      .state_o     (slot_state[g]),
      .idx_o       (slot_idx[g]),
      .eligible_o  (eligible[g]),
      .hit_o       (hit_flag[g]),
      .miss_o      (miss_flag[g])
    );
    assign mole_valid[g]                 = (slot_state[g] == S_UP);
    assign mole_idx[g*IDX_W +: IDX_W]    = slot_idx[g];
  end

  // sw_q follows sw on every cycle, including start and while disabled.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      lfsr_q       <= SEED;
      sw_q         <= '1;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wrong_q      <= 1'b0;
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
      sw_q   <= sw;
      if (start) begin
        tick_cnt_q   <= '0;
        hit_count_q  <= '0;
        miss_count_q <= '0;
        wrong_q      <= 1'b0;
      end else begin
        if (enable) tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
        hit_count_q  <= hit_sum;
        miss_count_q <= miss_sum;
        wrong_q      <= |(edges & ~mole_positions);
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wrong      = wrong_q;

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Parametrised successor to the fixed three-mole generator. Manages `N_MOLES` independent mole slots over `N_HOLES` holes. Each slot spawns a mole at a pseudo-random free hole, keeps it up for a runtime-selectable lifetime, and retires it as a hit (switch rising edge) or a miss (timeout). It sits between the switch synchroniser and the score/combo logic in `top_level`; its count outputs feed the scorer directly.

## Interface
- `N_HOLES`, 18, number of holes and switches (2..64)
- `N_MOLES`, 3, simultaneous mole slots (1..8, must be ≤ `N_HOLES`)
- `TICK_DIV`, 50000, `CLOCK_50` cycles per game tick (≥2)
- `SPAWN_GAP`, 250, idle ticks a slot waits after a hit or miss
- `LFSR_SEED`, 16'hACE1, LFSR reset value (zero is replaced by 16'h0001)
- `CLOCK_50` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset (driven from `KEY[0]`)
- `enable` in 1: level, game running
- `start` in 1: one-cycle pulse, synchronous round restart
- `life_ticks` in 16: mole lifetime in ticks (difficulty mode), sampled at spawn
- `sw` in `N_HOLES`: synchronised switch levels
- `mole_positions` out `N_HOLES`: one-hot-per-mole occupancy bitmap
- `mole_idx` out `N_MOLES*IDX_W`: packed hole index per slot, slot 0 in the LSBs; `IDX_W = clog2(N_HOLES)`
- `mole_valid` out `N_MOLES`: slot has a mole up
- `hit_count` out `CNT_W`: moles whacked this cycle; `CNT_W = clog2(N_MOLES+1)`
- `miss_count` out `CNT_W`: moles expired this cycle
- `wrong` out 1: at least one switch edge hit an empty hole this cycle

## Operation
- **Tick.** A counter runs 0..`TICK_DIV`-1 while `enable` is high and holds otherwise. `tick` pulses on wrap.
- **LFSR.** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle regardless of `enable` and is not affected by `start`.
- **Candidate.** `cand = lfsr[IDX_W-1:0]`. It is rejected when `cand ≥ N_HOLES` or `mole_positions[cand]` is set. A rejected candidate is retried next cycle; there is no modulo logic.
- **Slot FSM.** Two states, `S_IDLE` and `S_UP`, plus a 16-bit `gap` and a 16-bit `life` counter.
- **S_IDLE.** `gap` decrements on `tick` until it reaches 0. A slot with `gap==0` is spawn-eligible.
  - Only the lowest-index eligible slot is granted, one spawn per cycle, and only when `enable` is high and the candidate is valid.
  - On grant the slot moves to `S_UP` with `idx = cand` and `life = max(life_ticks, 1)`.
- **S_UP.** `life` decrements on `tick`.
  - Hit: a rising edge on `sw[idx]` moves the slot to `S_IDLE` with `gap = SPAWN_GAP`.
  - Expiry: a tick with `life==1` moves the slot to `S_IDLE` with `gap = SPAWN_GAP` and counts a miss.
- **Edges.** `edge = sw & ~sw_q`. Edges are processed only while `enable` is high. An edge on a hole with no mole asserts `wrong`. Multiple edges in one cycle are all processed.
- **Simultaneous hit and expiry** on the same slot in the same cycle count as a hit only.
- **Freed holes.** Occupancy for candidate checking uses the registered `mole_positions`, so a hole freed in cycle n can be re-spawned in cycle n+1 at the earliest.
- **`start`.** Overrides everything in its cycle:
  - all slots go to `S_IDLE` with `gap = slot_index` (staggered first spawns);
  - the tick counter is zeroed;
  - the count outputs and `wrong` are zeroed;
  - `sw_q` is loaded with `sw`.
- **`enable` low.** State is frozen: no tick, no spawn, no edge processing. `sw_q` still tracks `sw`.

## Timing
- **Reset.** Every output is 0. Slots reset to `S_IDLE` with `gap=0`, and the LFSR to `LFSR_SEED`. `sw_q` resets to all ones, so a switch held at reset must be released and re-raised to count.
- **Registered outputs.** All outputs are registered.
  - A switch edge seen at clock n produces `hit_count`/`wrong` and clears `mole_positions` in cycle n+1.
  - A grant at clock n sets `mole_valid`, `mole_idx` and `mole_positions` in cycle n+1.
  - An expiry tick at clock n produces `miss_count` in cycle n+1.
- **Count outputs** (`hit_count`, `miss_count`, `wrong`) are single-cycle and return to 0 the following cycle unless re-triggered.
- **Unique holes.** `mole_positions` has exactly `popcount(mole_valid)` bits set, and no two valid slots share an index.
- **Minimum occupancy.** A mole stays up at least (`life_ticks`-1)·`TICK_DIV`+1 cycles unless hit.
- **Reset mid-round.** An asynchronous reset abandons all moles immediately; no miss is reported.

## Structure
- **Package `mole_pkg`:**
  - the `slot_state_t` enum (`S_IDLE`, `S_UP`);
  - `LFSR_TAPS` = 16'hB400;
  - the `clog2` function;
  - the `TICK_W`/`LIFE_W` = 16 constants.
- **Sub-module `mole_slot`:** one slot FSM with its `gap` and `life` counters, hit/expiry detection and `idx` register. It is instantiated `N_MOLES` times via generate.
- **Top of `mole_scheduler`:** tick divider, LFSR, candidate check, priority grant, edge detector, popcount of the slot hit/miss flags, and the occupancy OR.

## Test plan
- **Reset/spawn:** reset, `start`, `enable=1`, `TICK_DIV=4`, `life_ticks=10`, seed 16'hACE1. Required: within 8 ticks `mole_valid=3'b111`, three distinct indices < 18, and `mole_positions` popcount = 3.
- **Hit:** raise `sw[mole_idx slot0]`. Required: next cycle `hit_count=1`, `mole_valid[0]=0`, that bit cleared; `mole_valid[0]` stays 0 for ≥ `SPAWN_GAP` ticks.
- **Miss:** no switches, `life_ticks=5`. Required: each mole retires after exactly 5 ticks with `miss_count=1` per slot, and never two moles on the same hole.
- **Simultaneous:** raise two mole switches and one empty-hole switch in the same cycle. Required: `hit_count=2` and `wrong=1`. Separately, align a hit with the expiry tick: required `hit_count=1`, `miss_count=0`.
- **Freeze:** `enable=0` for 100 cycles with a switch toggling. Required: outputs unchanged and counts 0; `sw` held high across reset gives no hit until re-raised.
- **Parametrisation:** `N_HOLES=9`, `N_MOLES=8`. Required: no two valid slots share an index and `IDX_W=4`. Also check that `start` mid-round clears all `mole_valid` next cycle with no `miss_count`.
